// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the run/halt/step controller.
// State encodings double as the LED display code.
package cpu_run_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int ICNT_W = 32;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

  // States that wait for a button before the CPU moves again
  function automatic logic is_parked(input run_state_e st);
    return (st == ST_HALT) || (st == ST_BREAK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-FF synchronizer, level debounce and
// a registered single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: turns debounced buttons and a
// PC breakpoint into the CPU clock-enable and a retire counter.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_halt,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc_current,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [ICNT_W-1:0] instr_count
);

  logic run_p;
  logic step_p;
  logic halt_p;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_run),
    .pulse_o(run_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_step),
    .pulse_o(step_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_halt),
    .pulse_o(halt_p)
  );

  run_state_e        state_q;
  run_state_e        state_d;
  logic              first_run_q;
  logic              first_run_d;
  logic [ICNT_W-1:0] instr_count_q;
  logic [ICNT_W-1:0] instr_count_d;
  logic              bp_hit;
  logic              en;

  // first_run lets a resume execute the instruction it trapped on
  assign bp_hit = bp_en && (pc_current == bp_addr)
               && !first_run_q && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT, ST_BREAK: begin
        if (halt_p)      state_d = ST_HALT;
        else if (step_p) state_d = ST_STEP;
        else if (run_p)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_p)      state_d = ST_HALT;
        else if (step_p) state_d = ST_HALT;
        else if (bp_hit) state_d = ST_BREAK;
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    en = 1'b0;
    if (state_q == ST_STEP) en = 1'b1;
    if (state_q == ST_RUN)  en = !halt_p && !step_p && !bp_hit;
    first_run_d   = (state_d == ST_RUN) && (state_q != ST_RUN);
    instr_count_d = instr_count_q + ICNT_W'(en);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HALT;
      first_run_q   <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      first_run_q   <= first_run_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cpu_en      = en;
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule
